// File: rtl/write_back_stage_pkg.sv
// Shared write-back types: register-file data/address, destination control and FIFO entry.
package write_back_stage_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned WB_FIFO_DEPTH   = 2;
    localparam int unsigned WB_STARVE_LIMIT = 4;

    typedef logic [DATA_W-1:0]     basic_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      w_enable;
        logic      is_forwardable;
        reg_addr_t rd_addr;
    } rd_ctrl_t;

    typedef struct packed {
        rd_ctrl_t    rd_ctrl;
        basic_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result buffer: synchronous FIFO with registered full/empty and no bypass.
module wb_result_fifo
    import write_back_stage_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally (power-of-two depth); full/empty come from the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage is not reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/write_back_stage.sv
// Merges the execute pipe and the buffered long-latency unit onto the register-file write port.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  rd_ctrl_t    ex_rd_ctrl,
    input  basic_data_t ex_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  rd_ctrl_t    lsu_rd_ctrl,
    input  basic_data_t lsu_data,
    output logic        stall_req,
    output rd_ctrl_t    rd_ctrl,
    output basic_data_t w_data
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t           fifo_head;
    wb_entry_t           push_entry;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ex_wants;
    logic                push;
    logic                grant_head;
    wb_entry_t           sel;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;
    logic                stall_next;

    assign ex_wants   = ex_valid && ex_rd_ctrl.w_enable;
    assign lsu_ready  = !fifo_full;
    assign push       = lsu_valid && !fifo_full;
    assign grant_head = !ex_wants && !fifo_empty;

    assign push_entry.rd_ctrl = lsu_rd_ctrl;
    assign push_entry.data    = lsu_data;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (grant_head),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Write-port arbitration: execute first, then FIFO head, else idle; x0 writes are squashed.
    always_comb begin
        sel = '0;
        if (ex_wants) begin
            sel.rd_ctrl = ex_rd_ctrl;
            sel.data    = ex_data;
        end else if (grant_head) begin
            sel = fifo_head;
        end
        if (sel.rd_ctrl.rd_addr == '0) begin
            sel.rd_ctrl.w_enable = 1'b0;
        end
    end

    // Starvation tracking: count lost grants of a waiting head, request a bubble at the limit.
    always_comb begin
        starve_next = starve_cnt;
        stall_next  = stall_req;
        if (fifo_empty || grant_head) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + STARVE_W'(1);
        end
        if (grant_head) begin
            stall_next = 1'b0;
        end else if (starve_cnt == STARVE_W'(STARVE_LIMIT)) begin
            stall_next = 1'b1;
        end
    end

    // Output and starvation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ctrl    <= '0;
            w_data     <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            rd_ctrl    <= sel.rd_ctrl;
            w_data     <= sel.data;
            starve_cnt <= starve_next;
            stall_req  <= stall_next;
        end
    end

    // Upstream must not issue a writing execute result while a bubble is requested.
    ex_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(stall_req && ex_wants));

    fifo_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_write_back_stage;
    import write_back_stage_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    rd_ctrl_t    ex_rd_ctrl;
    basic_data_t ex_data;
    logic        lsu_valid;
    logic        lsu_ready;
    rd_ctrl_t    lsu_rd_ctrl;
    basic_data_t lsu_data;
    logic        stall_req;
    rd_ctrl_t    rd_ctrl;
    basic_data_t w_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    write_back_stage #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_rd_ctrl  (ex_rd_ctrl),
        .ex_data     (ex_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd_ctrl (lsu_rd_ctrl),
        .lsu_data    (lsu_data),
        .stall_req   (stall_req),
        .rd_ctrl     (rd_ctrl),
        .w_data      (w_data)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending long-latency results in arrival order; 'waited' is how many cycles the
    // current head has been passed over. A bubble is requested once it exceeds LIMIT.
    wb_entry_t   mq[$];
    int          waited;
    logic        exp_we;
    rd_ctrl_t    exp_ctrl;
    basic_data_t exp_data;
    wb_entry_t   m_win;
    wb_entry_t   m_new;
    bit          m_took_head;
    bit          m_accept;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            waited   = 0;
            exp_we   = 1'b0;
            exp_ctrl = '0;
            exp_data = '0;
        end else begin
            m_accept    = lsu_valid && (mq.size() < DEPTH);
            m_took_head = 1'b0;
            m_win       = '0;
            if (ex_valid && ex_rd_ctrl.w_enable) begin
                m_win.rd_ctrl = ex_rd_ctrl;
                m_win.data    = ex_data;
                if (mq.size() > 0) waited = waited + 1;
            end else if (mq.size() > 0) begin
                m_win       = mq.pop_front();
                m_took_head = 1'b1;
                waited      = 0;
            end
            if (mq.size() == 0 && !m_took_head) waited = 0;
            if (m_accept) begin
                m_new.rd_ctrl = lsu_rd_ctrl;
                m_new.data    = lsu_data;
                mq.push_back(m_new);
            end
            exp_we   = m_win.rd_ctrl.w_enable && (m_win.rd_ctrl.rd_addr != 0);
            exp_ctrl = m_win.rd_ctrl;
            exp_data = m_win.data;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("m_wen", rd_ctrl.w_enable, exp_we);
        if (exp_we) begin
            check("m_rd", rd_ctrl.rd_addr, exp_ctrl.rd_addr);
            check("m_fwd", rd_ctrl.is_forwardable, exp_ctrl.is_forwardable);
            check("m_data", w_data, exp_data);
        end
        check("m_ready", lsu_ready, mq.size() < DEPTH);
        check("m_stall", stall_req, waited > LIMIT);
        if (!rst_n) check("m_rst_data", w_data, 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input int rd, input logic [31:0] d);
        ex_valid   = v;
        ex_rd_ctrl = '{w_enable: 1'b1, is_forwardable: 1'b1, rd_addr: 5'(rd)};
        ex_data    = d;
    endtask

    task automatic set_lsu(input logic v, input int rd, input logic [31:0] d);
        lsu_valid   = v;
        lsu_rd_ctrl = '{w_enable: 1'b1, is_forwardable: 1'b0, rd_addr: 5'(rd)};
        lsu_data    = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;
        bit  rdy;
        int  pex;
        int  plsu;

        rst_n = 1'b0;
        set_ex(0, 0, 0);
        set_lsu(0, 0, 0);
        repeat (3) tick();
        check("rst_wen", rd_ctrl.w_enable, 0);
        check("rst_wdata", w_data, 0);
        check("rst_stall", stall_req, 0);
        check("rst_ready", lsu_ready, 1);
        rst_n = 1'b1;
        tick();

        // Execute only: one-cycle latency, then idle.
        set_ex(1, 5, 32'h1234);
        tick();
        set_ex(0, 0, 0);
        check("ex_wen", rd_ctrl.w_enable, 1);
        check("ex_rd", rd_ctrl.rd_addr, 5);
        check("ex_data", w_data, 32'h1234);
        tick();
        check("ex_idle", rd_ctrl.w_enable, 0);

        // Long-latency only.
        set_lsu(1, 7, 32'hDEAD);
        tick();
        set_lsu(0, 0, 0);
        check("lsu_not_early", rd_ctrl.w_enable, 0);
        tick();
        check("lsu_wen", rd_ctrl.w_enable, 1);
        check("lsu_rd", rd_ctrl.rd_addr, 7);
        check("lsu_data", w_data, 32'hDEAD);

        // Back-to-back long-latency pushes drain on consecutive cycles.
        set_lsu(1, 10, 32'hA0);
        tick();
        set_lsu(1, 11, 32'hB0);
        tick();
        set_lsu(0, 0, 0);
        check("b2b_first_rd", rd_ctrl.rd_addr, 10);
        check("b2b_first_data", w_data, 32'hA0);
        tick();
        check("b2b_second_wen", rd_ctrl.w_enable, 1);
        check("b2b_second_rd", rd_ctrl.rd_addr, 11);
        tick();

        // Conflict: execute first, buffered result next cycle.
        set_ex(1, 3, 32'h33);
        set_lsu(1, 9, 32'h99);
        tick();
        set_ex(0, 0, 0);
        set_lsu(0, 0, 0);
        check("conf_first_rd", rd_ctrl.rd_addr, 3);
        check("conf_ready", lsu_ready, 1);
        tick();
        check("conf_second_rd", rd_ctrl.rd_addr, 9);
        check("conf_second_data", w_data, 32'h99);
        tick();

        // Destination x0 is squashed.
        set_ex(1, 0, 32'hFFFF);
        tick();
        set_ex(0, 0, 0);
        check("x0_wen", rd_ctrl.w_enable, 0);
        tick();

        // Full FIFO under a streaming execute pipe, then starvation bubble.
        set_ex(1, 1, 32'h100);
        set_lsu(1, 12, 32'hC1);
        tick();
        set_ex(1, 1, 32'h101);
        set_lsu(1, 13, 32'hC2);
        tick();
        check("full_ready", lsu_ready, 0);
        set_lsu(1, 14, 32'hC3);
        cyc   = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (stall_req) begin
                found = 1'b1;
            end else begin
                set_ex(1, 1, 32'(200 + i));
                tick();
                cyc++;
            end
        end
        check("stall_seen", found, 1);
        check("stall_latency", cyc, 5);
        check("full_hold_ready", lsu_ready, 0);
        set_ex(0, 0, 0);
        tick();
        check("bubble_head_data", w_data, 32'hC1);
        check("bubble_head_wen", rd_ctrl.w_enable, 1);
        check("stall_clear", stall_req, 0);
        check("ready_after_pop", lsu_ready, 1);
        tick();
        set_lsu(0, 0, 0);
        check("drain_second", w_data, 32'hC2);
        tick();
        check("held_offer_data", w_data, 32'hC3);
        check("held_offer_rd", rd_ctrl.rd_addr, 14);
        tick();

        // Reset mid-operation with two buffered entries.
        set_ex(1, 1, 32'h300);
        set_lsu(1, 15, 32'hD1);
        tick();
        set_lsu(1, 16, 32'hD2);
        tick();
        set_lsu(0, 0, 0);
        set_ex(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_wen", rd_ctrl.w_enable, 0);
        check("rstmid_data", w_data, 0);
        check("rstmid_ready", lsu_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", lsu_ready, 1);
        check("post_rst_idle0", rd_ctrl.w_enable, 0);
        tick();
        check("post_rst_idle1", rd_ctrl.w_enable, 0);
        tick();

        // Randomized traffic; the per-cycle compare does the checking.
        for (int seg = 0; seg < 4; seg++) begin
            pex  = (seg == 1) ? 95 : (seg == 2) ? 20 : 60;
            plsu = (seg == 2) ? 70 : 40;
            for (int c = 0; c < 500; c++) begin
                if (stall_req) begin
                    ex_valid = 1'b0;
                end else if ($urandom_range(99) < pex) begin
                    ex_valid = 1'b1;
                    ex_rd_ctrl.w_enable       = ($urandom_range(99) < 85);
                    ex_rd_ctrl.is_forwardable = 1'($urandom_range(1));
                    ex_rd_ctrl.rd_addr        = 5'($urandom_range(31));
                    ex_data                   = $urandom();
                end else begin
                    ex_valid = 1'b0;
                end
                if (seg == 3 && c == 250) begin
                    #2;
                    rst_n = 1'b0;
                    #4;
                    rst_n = 1'b1;
                end
                rdy = lsu_ready;
                tick();
                if (!lsu_valid || rdy) begin
                    if ($urandom_range(99) < plsu) begin
                        set_lsu(1, int'($urandom_range(31)), $urandom());
                        lsu_rd_ctrl.is_forwardable = 1'($urandom_range(1));
                    end else begin
                        lsu_valid = 1'b0;
                    end
                end
            end
        end

        set_ex(0, 0, 0);
        set_lsu(0, 0, 0);
        repeat (6) tick();
        check("final_ready", lsu_ready, 1);
        check("final_stall", stall_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
